// File: rtl/prim_pad_input_filter_if.sv
// Pad-input conditioner bus: raw pad levels and filter controls in,
// filtered level and edge events out.
interface prim_pad_input_filter_if #(
    parameter int Width    = 8,
    parameter int CntWidth = 4
);
    logic [Width-1:0]    in_i;
    logic [Width-1:0]    filter_en_i;
    logic [CntWidth-1:0] filter_cycles_i;
    logic [Width-1:0]    out_o;
    logic [Width-1:0]    rise_o;
    logic [Width-1:0]    fall_o;

    modport master (
        output in_i, filter_en_i, filter_cycles_i,
        input  out_o, rise_o, fall_o
    );

    modport slave (
        input  in_i, filter_en_i, filter_cycles_i,
        output out_o, rise_o, fall_o
    );
endinterface

// File: rtl/prim_pad_input_filter.sv
// prim_pad_input_filter: two-flop synchronizer plus per-bit glitch filter
// for pad inputs. A new level is accepted after filter_cycles_i+1
// consecutive mismatching cycles; N=0 or a disabled filter is a plain
// passthrough with three cycles of latency.
// Optional feature macro: PRIM_PAD_FILTER_EDGE_EN -- when defined, the
// registered rise_o/fall_o event pulses are built; otherwise they are 0.

// One pad bit: synchronizer, stability counter, edge detect.
module prim_pad_input_filter_lane #(
    parameter int CntWidth = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                in_i,
    input  logic                en_i,
    input  logic [CntWidth-1:0] n_i,
    output logic                out_o,
    output logic                rise_o,
    output logic                fall_o
);
    logic                sync1, sync2, stable, stable_next;
    logic [CntWidth-1:0] cnt, cnt_next;

    // Filter decision: any match or acceptance clears the count, so a
    // short glitch leaves no partial credit behind.
    always_comb begin
        stable_next = stable;
        cnt_next    = '0;
        if (!en_i) begin
            stable_next = sync2;
        end else if (sync2 != stable) begin
            if (cnt >= n_i) stable_next = sync2;
            else            cnt_next    = cnt + 1'b1;
        end
    end

    // Synchronizer, filtered level and counter; everything clears on reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            sync1  <= in_i;
            sync2  <= sync1;
            stable <= stable_next;
            cnt    <= cnt_next;
        end
    end

    assign out_o = stable;

`ifdef PRIM_PAD_FILTER_EDGE_EN
    logic rise_q, fall_q;

    // Edge pulses registered alongside stable; reset forces them low so
    // clearing a high level never reports a fall.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= ~stable & stable_next;
            fall_q <= stable & ~stable_next;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;
`else
    assign rise_o = 1'b0;
    assign fall_o = 1'b0;
`endif
endmodule

// Top: Width independent lanes sharing one threshold.
module prim_pad_input_filter #(
    parameter int Width    = 8,
    parameter int CntWidth = 4
) (
    input logic                     clk_i,
    input logic                     rst_i,
    prim_pad_input_filter_if.slave  bus
);
    logic [Width-1:0] out_w, rise_w, fall_w;

    for (genvar i = 0; i < Width; i++) begin : g_lane
        prim_pad_input_filter_lane #(.CntWidth(CntWidth)) u_lane (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .in_i   (bus.in_i[i]),
            .en_i   (bus.filter_en_i[i]),
            .n_i    (bus.filter_cycles_i),
            .out_o  (out_w[i]),
            .rise_o (rise_w[i]),
            .fall_o (fall_w[i])
        );
    end

    assign bus.out_o  = out_w;
    assign bus.rise_o = rise_w;
    assign bus.fall_o = fall_w;
endmodule
